// File: rtl/dff_b.sv
`default_nettype none
// ============================================================================
// Module   : dff_b
// Purpose  : Positive-edge D register with synchronous active-high reset.
//            Parameterised width, reset value and stage count, so it serves
//            as a plain DFF, a bus register or a short delay line.
// Ports    : q   - output [WIDTH-1:0], driven from the last register stage
//            d   - input  [WIDTH-1:0], captured on every non-reset rising edge
//            clk - input, all state updates on the rising edge
//            rst - input, synchronous active-high, loads RST_VAL everywhere
// Revision : 1.0 - initial release
// ============================================================================
module dff_b #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      DEPTH   = 1
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Stage 0 sees the port; later stages see their predecessor.
    if (i == 0) begin : g_head
      assign stage_d[i] = d;
    end else begin : g_tail
      assign stage_d[i] = stage_q[i-1];
    end

    // Reset wins over data on the same edge and clears in-flight values.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q[i] <= RST_VAL;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_dff_b.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_b
// Purpose  : Self-checking bench for dff_b. One default instance (1-bit,
//            depth 1, reset 0) and one pipeline instance (8-bit, depth 3,
//            reset 8'hA5), checked against a queue-based delay-line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_b;

  localparam int unsigned DA    = 1;
  localparam int unsigned DB    = 3;
  localparam logic [7:0]  RSTVB = 8'hA5;

  logic       clk;
  logic       rst_a, rst_b;
  logic [0:0] d_a, q_a;
  logic [7:0] d_b, q_b;

  int total = 0;
  int bad   = 0;

  // Model: data enters a queue on every non-reset edge; output is the value
  // that entered DEPTH edges ago, or the reset value until the queue refills.
  logic [7:0] mq_a[$];
  logic [7:0] mq_b[$];
  int         cnt_a = 0;
  int         cnt_b = 0;
  logic [7:0] exp_a, exp_b;

  dff_b u_dut_a (
    .q   (q_a),
    .d   (d_a),
    .clk (clk),
    .rst (rst_a)
  );

  dff_b #(
    .WIDTH   (8),
    .RST_VAL (RSTVB),
    .DEPTH   (DB)
  ) u_dut_b (
    .q   (q_b),
    .d   (d_b),
    .clk (clk),
    .rst (rst_b)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst_a) begin
      cnt_a = 0;
      mq_a.delete();
    end else begin
      cnt_a++;
      mq_a.push_back({7'd0, d_a});
      if (mq_a.size() > DA) void'(mq_a.pop_front());
    end
    exp_a = (cnt_a >= DA) ? mq_a[0] : 8'h00;

    if (rst_b) begin
      cnt_b = 0;
      mq_b.delete();
    end else begin
      cnt_b++;
      mq_b.push_back(d_b);
      if (mq_b.size() > DB) void'(mq_b.pop_front());
    end
    exp_b = (cnt_b >= DB) ? mq_b[0] : RSTVB;
  endtask

  // Drive inputs now (falling edge or t=0), take one rising edge, then
  // return on the next falling edge ready for checking.
  task automatic step(input logic ra, input logic da, input logic rb, input logic [7:0] db);
    rst_a = ra; d_a = da; rst_b = rb; d_b = db;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; d_a = 1'b0; rst_b = 1'b1; d_b = 8'h00;

    // Reset hold, 0..100 ns: q stays 0 after every edge.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'($urandom));
      chk("rst_hold_a", {7'd0, q_a}, 8'h00);
      chk("rst_hold_b", q_b, RSTVB);
    end

    // Reset release with data: nothing shows before the 110 ns edge.
    rst_a = 1'b0; d_a = 1'b1;
    #5 chk("rel_before_edge", {7'd0, q_a}, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("rel_after_edge", {7'd0, q_a}, 8'h01);

    // Data toggle.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("toggle_0", {7'd0, q_a}, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("toggle_1", {7'd0, q_a}, 8'h01);

    // Reset priority over d=1, then recovery with d held.
    step(1'b1, 1'b1, 1'b1, 8'h00);
    chk("rst_priority", {7'd0, q_a}, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("rst_recover", {7'd0, q_a}, 8'h01);

    // Glitch immunity: d pulse low, then rst pulse high, between edges.
    #2 d_a = 1'b0;
    #5 d_a = 1'b1;
    chk("glitch_d_mid", {7'd0, q_a}, 8'h01);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("glitch_d_after", {7'd0, q_a}, 8'h01);
    #2 rst_a = 1'b1;
    #5 rst_a = 1'b0;
    chk("glitch_rst_mid", {7'd0, q_a}, 8'h01);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("glitch_rst_after", {7'd0, q_a}, 8'h01);

    // Pipeline: release with 3C; reset value persists for two edges.
    step(1'b0, 1'b0, 1'b0, 8'h3C);
    chk("pipe_e1", q_b, RSTVB);
    step(1'b0, 1'b0, 1'b0, 8'h11);
    chk("pipe_e2", q_b, RSTVB);
    step(1'b0, 1'b0, 1'b0, 8'h22);
    chk("pipe_e3", q_b, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 8'h33);
    chk("pipe_e4", q_b, 8'h11);
    // Mid-stream reset discards 22/33.
    step(1'b0, 1'b0, 1'b1, 8'h44);
    chk("pipe_midrst", q_b, RSTVB);
    step(1'b0, 1'b0, 1'b0, 8'h55);
    chk("pipe_post_rst", q_b, RSTVB);

    // Randomized stream against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), 1'($urandom),
           ($urandom_range(0, 11) == 0), 8'($urandom));
      chk("rand_a", {7'd0, q_a}, exp_a);
      chk("rand_b", q_b, exp_b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
